// File: rtl/r5_operand_sequencer_if.sv
// Stream and operand-pair bus between the sample source, the radix-5 sequencer
// and the downstream complex adder stage.
interface r5_operand_sequencer_if #(
   parameter int DW = 32
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_re;
   logic [DW-1:0] in_img;
   logic          in_last;
   logic          op_valid;
   logic          op_ready;
   logic [DW-1:0] a_re;
   logic [DW-1:0] a_img;
   logic [DW-1:0] b_re;
   logic [DW-1:0] b_img;
   logic [1:0]    op_idx;
   logic          op_last;
   logic          frame_err;

   modport master (
      output in_valid, in_re, in_img, in_last, op_ready,
      input  in_ready, op_valid, a_re, a_img, b_re, b_img, op_idx, op_last, frame_err
   );

   modport slave (
      input  in_valid, in_re, in_img, in_last, op_ready,
      output in_ready, op_valid, a_re, a_img, b_re, b_img, op_idx, op_last, frame_err
   );
endinterface

// File: rtl/r5_operand_sequencer.sv
// Radix-5 butterfly input stage: ping-pong buffers 5-sample frames and issues
// operand pairs (x1,x4), (x2,x3), (x0,0) to the complex adder.
module r5_operand_sequencer #(
   parameter int DW  = 32,
   parameter int NPT = 5
) (
   input logic                   clk,
   input logic                   rst_n,
   r5_operand_sequencer_if.slave bus
);

   generate
      if (NPT != 5) begin : g_npt_check
         $error("r5_operand_sequencer: NPT must be 5");
      end
   endgenerate

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_ISSUE = 1'b1
   } state_e;

   state_e        state_q, state_d;
   logic          rb_q, rb_d;
   logic          wb_q, wb_d;
   logic [2:0]    widx_q, widx_d;
   logic [1:0]    full_q, full_d;
   logic [1:0]    idx_q, idx_d;
   logic          op_valid_q, op_valid_d;
   logic          op_last_q, op_last_d;
   logic          frame_err_q, frame_err_d;
   logic [DW-1:0] a_re_q, a_re_d;
   logic [DW-1:0] a_img_q, a_img_d;
   logic [DW-1:0] b_re_q, b_re_d;
   logic [DW-1:0] b_img_q, b_img_d;
   logic [DW-1:0] bank_re_q  [2][NPT];
   logic [DW-1:0] bank_img_q [2][NPT];

   logic in_ready_s;
   logic acc_s;
   logic fire_s;
   logic wr_en_s;
   logic set_full_s;
   logic clr_full_s;

   // A freed bank only reopens after the free edge because ready looks at the flopped full bits.
   assign in_ready_s = rst_n & ~full_q[wb_q];
   assign acc_s      = bus.in_valid & in_ready_s;
   assign fire_s     = op_valid_q & bus.op_ready;

   // Write path: sample indexing, frame commit and framing-error detection.
   always_comb begin
      widx_d      = widx_q;
      wb_d        = wb_q;
      wr_en_s     = 1'b0;
      set_full_s  = 1'b0;
      frame_err_d = 1'b0;
      if (acc_s) begin
         wr_en_s = 1'b1;
         if (widx_q == 3'd4) begin
            widx_d      = 3'd0;
            wb_d        = ~wb_q;
            set_full_s  = 1'b1;
            frame_err_d = ~bus.in_last;
         end else if (bus.in_last) begin
            widx_d      = 3'd0;
            frame_err_d = 1'b1;
         end else begin
            widx_d = widx_q + 3'd1;
         end
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // Read FSM next state: pair stepping, bank release and back-to-back continuation.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      rb_d       = rb_q;
      clr_full_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (full_q[rb_q]) begin
               state_d = S_ISSUE;
               idx_d   = 2'd0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (fire_s) begin
               if (idx_q == 2'd2) begin
                  clr_full_s = 1'b1;
                  rb_d       = ~rb_q;
                  idx_d      = 2'd0;
                  state_d    = full_q[~rb_q] ? S_ISSUE : S_IDLE;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end else begin
               state_d = S_ISSUE;
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
         end
      endcase
   end

   // Bank occupancy: commit and release always target different banks.
   always_comb begin
      full_d = full_q;
      if (set_full_s) begin
         full_d[wb_q] = 1'b1;
      end else begin
         full_d[wb_q] = full_q[wb_q];
      end
      if (clr_full_s) begin
         full_d[rb_q] = 1'b0;
      end else begin
         full_d[rb_q] = full_d[rb_q];
      end
   end

   // Output decode: operand pair for the next cycle, zero while idle.
   always_comb begin
      op_valid_d = (state_d == S_ISSUE);
      op_last_d  = 1'b0;
      a_re_d     = '0;
      a_img_d    = '0;
      b_re_d     = '0;
      b_img_d    = '0;
      if (op_valid_d) begin
         case (idx_d)
            2'd0: begin
               a_re_d  = bank_re_q[rb_d][3'd1];
               a_img_d = bank_img_q[rb_d][3'd1];
               b_re_d  = bank_re_q[rb_d][3'd4];
               b_img_d = bank_img_q[rb_d][3'd4];
            end
            2'd1: begin
               a_re_d  = bank_re_q[rb_d][3'd2];
               a_img_d = bank_img_q[rb_d][3'd2];
               b_re_d  = bank_re_q[rb_d][3'd3];
               b_img_d = bank_img_q[rb_d][3'd3];
            end
            2'd2: begin
               a_re_d    = bank_re_q[rb_d][3'd0];
               a_img_d   = bank_img_q[rb_d][3'd0];
               op_last_d = 1'b1;
            end
            default: begin
               op_last_d = 1'b0;
            end
         endcase
      end else begin
         op_last_d = 1'b0;
      end
   end

   // State, bank storage and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rb_q        <= 1'b0;
         wb_q        <= 1'b0;
         widx_q      <= 3'd0;
         full_q      <= 2'b00;
         idx_q       <= 2'd0;
         op_valid_q  <= 1'b0;
         op_last_q   <= 1'b0;
         frame_err_q <= 1'b0;
         a_re_q      <= '0;
         a_img_q     <= '0;
         b_re_q      <= '0;
         b_img_q     <= '0;
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NPT; i++) begin
               bank_re_q[b][i]  <= '0;
               bank_img_q[b][i] <= '0;
            end
         end
      end else begin
         state_q     <= state_d;
         rb_q        <= rb_d;
         wb_q        <= wb_d;
         widx_q      <= widx_d;
         full_q      <= full_d;
         idx_q       <= idx_d;
         op_valid_q  <= op_valid_d;
         op_last_q   <= op_last_d;
         frame_err_q <= frame_err_d;
         a_re_q      <= a_re_d;
         a_img_q     <= a_img_d;
         b_re_q      <= b_re_d;
         b_img_q     <= b_img_d;
         if (wr_en_s) begin
            bank_re_q[wb_q][widx_q]  <= bus.in_re;
            bank_img_q[wb_q][widx_q] <= bus.in_img;
         end
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.op_valid  = op_valid_q;
   assign bus.op_idx    = idx_q;
   assign bus.op_last   = op_last_q;
   assign bus.frame_err = frame_err_q;
   assign bus.a_re      = a_re_q;
   assign bus.a_img     = a_img_q;
   assign bus.b_re      = b_re_q;
   assign bus.b_img     = b_img_q;

endmodule

// File: tb/tb_r5_operand_sequencer.sv
// Self-checking bench for r5_operand_sequencer: directed scenarios plus randomized
// frames checked against a frame-level reference model of the expected pair stream.
module tb_r5_operand_sequencer;
   localparam int DW = 32;

   typedef struct packed {
      logic [31:0] a_re;
      logic [31:0] a_img;
      logic [31:0] b_re;
      logic [31:0] b_img;
      logic [1:0]  idx;
      logic        last;
   } pair_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   r5_operand_sequencer_if #(.DW(DW)) bus ();
   r5_operand_sequencer #(.DW(DW), .NPT(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int    n_checks = 0;
   int    n_fail   = 0;
   int    err_cycles   = 0;
   int    valid_cycles = 0;
   bit    stall_seen   = 1'b0;
   pair_t got_q[$];
   pair_t exp_q[$];
   logic [31:0] fr_re [5];
   logic [31:0] fr_im [5];

   // Monitor: pairs transferred on the coming rising edge, error/valid activity.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.op_valid && bus.op_ready)
            got_q.push_back({bus.a_re, bus.a_img, bus.b_re, bus.b_img, bus.op_idx, bus.op_last});
         if (bus.frame_err) err_cycles++;
         if (bus.op_valid) valid_cycles++;
      end
   end

   // Reference: a committed frame yields (x1,x4), (x2,x3), (x0,0) in that order.
   function automatic void model_frame();
      pair_t p;
      for (int k = 0; k < 3; k++) begin
         p.a_re  = (k == 2) ? fr_re[0] : fr_re[k + 1];
         p.a_img = (k == 2) ? fr_im[0] : fr_im[k + 1];
         p.b_re  = (k == 2) ? 32'h0 : fr_re[4 - k];
         p.b_img = (k == 2) ? 32'h0 : fr_im[4 - k];
         p.idx   = 2'(k);
         p.last  = (k == 2);
         exp_q.push_back(p);
      end
   endfunction

   function automatic void fill_random();
      for (int i = 0; i < 5; i++) begin
         fr_re[i] = $urandom;
         fr_im[i] = $urandom;
      end
   endfunction

   task automatic send_sample(input logic [31:0] re, input logic [31:0] im,
                              input logic last, output bit waited);
      int n;
      bit ok;
      n = 0; ok = 1'b0; waited = 1'b0;
      bus.in_valid = 1'b1; bus.in_re = re; bus.in_img = im; bus.in_last = last;
      while (!ok && n < 500) begin
         @(negedge clk);
         ok = bus.in_ready;
         if (!ok) waited = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      if (!ok) begin
         n_checks++; n_fail++;
         $display("FAIL send_timeout: in_ready stayed %b, required 1", bus.in_ready);
      end
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
   endtask

   task automatic send_frame(input int nsamp, input int last_pos, input int gap_max);
      bit w;
      for (int i = 0; i < nsamp; i++) begin
         send_sample(fr_re[i], fr_im[i], (i == last_pos), w);
         if (w) stall_seen = 1'b1;
         if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      end
   endtask

   task automatic wait_ops(input int n, output bit ok);
      int c;
      c = 0;
      while (got_q.size() < n && c < 3000) begin @(posedge clk); #1; c++; end
      ok = (got_q.size() >= n);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.op_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: ready=%b valid=%b err=%b, required 0 0 0", bus.in_ready, bus.op_valid, bus.frame_err);
      end
      n_checks++;
      if ({bus.a_re, bus.a_img, bus.b_re, bus.b_img, bus.op_idx, bus.op_last} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: a=%h/%h b=%h/%h idx=%0d last=%b, required all 0", bus.a_re, bus.a_img, bus.b_re, bus.b_img, bus.op_idx, bus.op_last);
      end
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_release_ready: got %b, required 1", bus.in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      bit ok;
      bus.op_ready = 1'b1;
      fr_re = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};
      fr_im = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      model_frame();
      send_frame(5, 4, 0);
      n_checks++;
      if (bus.op_valid !== 1'b0) begin
         n_fail++; $display("FAIL basic_latency_early: op_valid=%b at x4 accept, required 0", bus.op_valid);
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus.op_valid !== 1'b1 || bus.op_idx !== 2'd0) begin
         n_fail++; $display("FAIL basic_latency: op_valid=%b idx=%0d, required 1 0", bus.op_valid, bus.op_idx);
      end
      wait_ops(3, ok);
      n_checks++;
      if (!ok || got_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL basic_count: got %0d pairs, required %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL basic_pair %0d: got %h, required %h", i, got_q[i], exp_q[i]);
         end
      end
      repeat (2) begin @(posedge clk); #1; end
      n_checks++;
      if (bus.op_valid !== 1'b0) begin
         n_fail++; $display("FAIL basic_idle: op_valid=%b after frame, required 0", bus.op_valid);
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_back_to_back();
      bit ok;
      bus.op_ready = 1'b1;
      stall_seen = 1'b0;
      for (int f = 0; f < 2; f++) begin
         fill_random(); model_frame(); send_frame(5, 4, 0);
      end
      n_checks++;
      if (stall_seen) begin
         n_fail++; $display("FAIL b2b_ready: in_ready dropped (stall=%b), required no stall", stall_seen);
      end
      wait_ops(6, ok);
      n_checks++;
      if (!ok || got_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL b2b_count: got %0d pairs, required %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL b2b_pair %0d: got %h, required %h", i, got_q[i], exp_q[i]);
         end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_stall();
      bit ok;
      int c;
      pair_t snap, cur;
      bus.op_ready = 1'b0;
      fill_random(); model_frame(); send_frame(5, 4, 0);
      c = 0;
      while (!bus.op_valid && c < 50) begin @(posedge clk); #1; c++; end
      bus.op_ready = 1'b1;
      @(posedge clk); #1;
      bus.op_ready = 1'b0;
      snap = {bus.a_re, bus.a_img, bus.b_re, bus.b_img, bus.op_idx, bus.op_last};
      n_checks++;
      if (bus.op_valid !== 1'b1 || snap.idx !== 2'd1) begin
         n_fail++; $display("FAIL stall_idx: valid=%b idx=%0d, required 1 1", bus.op_valid, snap.idx);
      end
      fill_random(); model_frame(); send_frame(5, 4, 0);
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
         n_fail++; $display("FAIL stall_ready_drop: in_ready=%b with both banks full, required 0", bus.in_ready);
      end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         cur = {bus.a_re, bus.a_img, bus.b_re, bus.b_img, bus.op_idx, bus.op_last};
         n_checks++;
         if (bus.op_valid !== 1'b1 || cur !== snap) begin
            n_fail++; $display("FAIL stall_hold cycle %0d: got %h valid=%b, required %h", k, cur, bus.op_valid, snap);
         end
      end
      @(posedge clk); #1;
      bus.op_ready = 1'b1;
      wait_ops(6, ok);
      n_checks++;
      if (!ok || got_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL stall_count: got %0d pairs, required %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL stall_pair %0d: got %h, required %h", i, got_q[i], exp_q[i]);
         end
      end
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL stall_ready_back: in_ready=%b after drain, required 1", bus.in_ready);
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_early_last();
      bit ok;
      int e0, v0;
      bus.op_ready = 1'b1;
      e0 = err_cycles; v0 = valid_cycles;
      fill_random(); send_frame(3, 2, 0);
      repeat (10) begin @(posedge clk); #1; end
      n_checks++;
      if (err_cycles - e0 != 1 || valid_cycles != v0) begin
         n_fail++; $display("FAIL early_last: err cycles=%0d valid cycles=%0d, required 1 0", err_cycles - e0, valid_cycles - v0);
      end
      fill_random(); model_frame(); send_frame(5, 4, 0);
      wait_ops(3, ok);
      n_checks++;
      if (!ok || got_q.size() != exp_q.size() || err_cycles - e0 != 1) begin
         n_fail++; $display("FAIL early_recover: pairs=%0d err=%0d, required %0d 1", got_q.size(), err_cycles - e0, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL early_pair %0d: got %h, required %h", i, got_q[i], exp_q[i]);
         end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_missing_last();
      bit ok;
      int e0;
      bus.op_ready = 1'b1;
      e0 = err_cycles;
      fill_random(); model_frame(); send_frame(5, -1, 0);
      wait_ops(3, ok);
      n_checks++;
      if (!ok || got_q.size() != exp_q.size() || err_cycles - e0 != 1) begin
         n_fail++; $display("FAIL missing_last: pairs=%0d err=%0d, required %0d 1", got_q.size(), err_cycles - e0, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL missing_pair %0d: got %h, required %h", i, got_q[i], exp_q[i]);
         end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset_mid_issue();
      bit ok;
      int c, v0;
      bus.op_ready = 1'b0;
      fill_random(); send_frame(5, 4, 0);
      fill_random(); send_frame(2, -1, 0);
      c = 0;
      while (!bus.op_valid && c < 50) begin @(posedge clk); #1; c++; end
      bus.op_ready = 1'b1;
      @(posedge clk); #1;
      bus.op_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.op_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.op_idx !== 2'd0) begin
         n_fail++; $display("FAIL midreset: valid=%b ready=%b idx=%0d, required 0 0 0", bus.op_valid, bus.in_ready, bus.op_idx);
      end
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b1;
      got_q.delete(); exp_q.delete();
      v0 = valid_cycles;
      bus.op_ready = 1'b1;
      repeat (5) begin @(posedge clk); #1; end
      n_checks++;
      if (valid_cycles != v0) begin
         n_fail++; $display("FAIL midreset_stale: %0d valid cycles after reset, required 0", valid_cycles - v0);
      end
      fill_random(); model_frame(); send_frame(5, 4, 0);
      wait_ops(3, ok);
      n_checks++;
      if (!ok || got_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL midreset_count: got %0d pairs, required %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL midreset_pair %0d: got %h, required %h", i, got_q[i], exp_q[i]);
         end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_random();
      bit ok, done;
      int e0, n_err, kind, pos;
      done = 1'b0; n_err = 0; e0 = err_cycles;
      fork
         begin
            for (int f = 0; f < 40; f++) begin
               fill_random();
               kind = $urandom_range(0, 9);
               if (kind == 0) begin
                  pos = $urandom_range(0, 3);
                  n_err++;
                  send_frame(pos + 1, pos, 2);
               end else if (kind == 1) begin
                  n_err++;
                  model_frame(); send_frame(5, -1, 2);
               end else begin
                  model_frame(); send_frame(5, 4, 2);
               end
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               bus.op_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      bus.op_ready = 1'b1;
      wait_ops(exp_q.size(), ok);
      repeat (3) begin @(posedge clk); #1; end
      n_checks++;
      if (!ok || got_q.size() != exp_q.size() || err_cycles - e0 != n_err) begin
         n_fail++; $display("FAIL random_count: pairs=%0d err=%0d, required %0d %0d", got_q.size(), err_cycles - e0, exp_q.size(), n_err);
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL random_pair %0d: got %h, required %h", i, got_q[i], exp_q[i]);
         end
      end
      got_q.delete(); exp_q.delete();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_re    = '0;
      bus.in_img   = '0;
      bus.in_last  = 1'b0;
      bus.op_ready = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_stall();
      test_early_last();
      test_missing_last();
      test_reset_mid_issue();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
